unidade_desvio: RTL and testbench

Branch resolution unit for the Lapido core: the consumer side of the flags register. It accepts one branch request at a time from the decoder and snapshots the stored z/c/s/o flags, waiting if a flags update is still in flight. It then evaluates the jump condition and either drives a PC load with a pipeline flush, or acknowledges a not-taken branch. `jal` also drives a link-register write.

---
 rtl/unidade_desvio.sv | 171 +++++++++++++++++
 tb/tb_unidade_desvio.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/unidade_desvio.sv
// unidade_desvio: branch resolution unit of the Lapido core.
// Takes one branch request at a time, snapshots the z/c/s/o flags (stalling
// while a flag-writing ALU op is still in flight), evaluates the jump
// condition and either loads the PC with a pipeline flush or acknowledges a
// not-taken branch. jal additionally writes the link register.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no branch in progress; accepts req when ack is low
// WAITF  | request latched, waiting for flags_pend to fall
// EVAL   | flags snapshot held, outcome registered for the ack cycle
// FLUSH  | taken branch, flush held for FLUSH_CYCLES cycles
module unidade_desvio #(
  parameter int ADDR_W       = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              r,
  input  logic              req,
  input  logic [1:0]        op,
  input  logic [2:0]        sel,
  input  logic [ADDR_W-1:0] target,
  input  logic [ADDR_W-1:0] pc_next,
  input  logic [3:0]        flagsO,
  input  logic              flags_pend,
  output logic              ack,
  output logic              taken,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_target,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_data,
  output logic              flush,
  output logic              busy
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  localparam logic [1:0] OP_J   = 2'b00;
  localparam logic [1:0] OP_JT  = 2'b01;
  localparam logic [1:0] OP_JF  = 2'b10;
  localparam logic [1:0] OP_JAL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAITF = 2'd1,
    S_EVAL  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        op_q;
  logic [2:0]        sel_q;
  logic [ADDR_W-1:0] target_q;
  logic [ADDR_W-1:0] pc_next_q;
  logic [3:0]        flags_q;

  logic              ack_q;
  logic              taken_q;
  logic              pc_load_q;
  logic              link_we_q;
  logic [ADDR_W-1:0] pc_target_q;
  logic [ADDR_W-1:0] link_data_q;

  logic              cnd_d;
  logic              taken_d;

  // Condition and outcome from the flags snapshot and the latched request.
  always_comb begin
    cnd_d   = 1'b0;
    taken_d = 1'b0;
    unique case (sel_q)
      3'b000:  cnd_d = 1'b1;
      3'b001:  cnd_d = flags_q[2];
      3'b010:  cnd_d = flags_q[0];
      3'b011:  cnd_d = flags_q[1];
      3'b100:  cnd_d = flags_q[2] | flags_q[0];
      3'b101:  cnd_d = flags_q[3];
      default: cnd_d = 1'b0;
    endcase
    unique case (op_q)
      OP_J:    taken_d = 1'b1;
      OP_JT:   taken_d = cnd_d;
      OP_JF:   taken_d = ~cnd_d;
      OP_JAL:  taken_d = 1'b1;
      default: taken_d = 1'b0;
    endcase
  end

  // Sequencer with registered strobes; reset drops any in-flight request.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      sel_q       <= '0;
      target_q    <= '0;
      pc_next_q   <= '0;
      flags_q     <= '0;
      ack_q       <= 1'b0;
      taken_q     <= 1'b0;
      pc_load_q   <= 1'b0;
      link_we_q   <= 1'b0;
      pc_target_q <= '0;
      link_data_q <= '0;
    end else begin
      ack_q     <= 1'b0;
      taken_q   <= 1'b0;
      pc_load_q <= 1'b0;
      link_we_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          // ack_q high means this is the ack cycle of a not-taken branch.
          if (req && !ack_q) begin
            op_q      <= op;
            sel_q     <= sel;
            target_q  <= target;
            pc_next_q <= pc_next;
            if (!flags_pend) begin
              flags_q <= flagsO;
              state_q <= S_EVAL;
            end else begin
              state_q <= S_WAITF;
            end
          end
        end
        S_WAITF: begin
          if (!flags_pend) begin
            flags_q <= flagsO;
            state_q <= S_EVAL;
          end
        end
        S_EVAL: begin
          ack_q   <= 1'b1;
          taken_q <= taken_d;
          if (op_q == OP_JAL) begin
            link_we_q   <= 1'b1;
            link_data_q <= pc_next_q;
          end
          if (taken_d) begin
            pc_load_q   <= 1'b1;
            pc_target_q <= target_q;
            cnt_q       <= CNT_LOAD;
            state_q     <= S_FLUSH;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_FLUSH: begin
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack       = ack_q;
  assign taken     = taken_q;
  assign pc_load   = pc_load_q;
  assign link_we   = link_we_q;
  assign pc_target = pc_target_q;
  assign link_data = link_data_q;
  assign flush     = (state_q == S_FLUSH);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_unidade_desvio.sv
// Scoreboard bench for unidade_desvio: the driver schedules each branch from
// a cycle-level model of the unit's availability and pushes the expected
// response; a monitor checks every cycle against those expectations.
module tb_unidade_desvio;

  localparam int FC   = 2;
  localparam int MAXC = 8192;

  logic        clk = 1'b0;
  logic        r;
  logic        req;
  logic [1:0]  op;
  logic [2:0]  sel;
  logic [15:0] target;
  logic [15:0] pc_next;
  logic [3:0]  flagsO;
  logic        flags_pend;
  logic        ack, taken, pc_load, link_we, flush, busy;
  logic [15:0] pc_target, link_data;

  unidade_desvio #(.ADDR_W(16), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .r(r), .req(req), .op(op), .sel(sel), .target(target),
    .pc_next(pc_next), .flagsO(flagsO), .flags_pend(flags_pend),
    .ack(ack), .taken(taken), .pc_load(pc_load), .pc_target(pc_target),
    .link_we(link_we), .link_data(link_data), .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ack_c;
    bit          tk;
    logic [1:0]  op;
    logic [15:0] tgt;
    logic [15:0] pcn;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  bit          exp_busy[MAXC];
  bit          exp_flush[MAXC];
  int          cyc = 0;
  int          free_c = 0;
  int          n_pass = 0;
  int          n_total = 0;
  bit          mon_en = 1'b0;
  logic [15:0] last_tgt = '0;
  logic [15:0] last_link = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  function automatic bit model_taken(input logic [1:0] o, input logic [2:0] s, input logic [3:0] f);
    bit z, c, n, v, cnd;
    z = f[0]; c = f[1]; n = f[2]; v = f[3];
    case (s)
      3'd0: cnd = 1;
      3'd1: cnd = n;
      3'd2: cnd = z;
      3'd3: cnd = c;
      3'd4: cnd = n | z;
      3'd5: cnd = v;
      default: cnd = 0;
    endcase
    if (o == 2'b01) return cnd;
    if (o == 2'b10) return !cnd;
    return 1;
  endfunction

  // Called at a negedge; returns at the negedge of the expected ack cycle
  // with req still high.
  task automatic txn(input logic [1:0] o, input logic [2:0] s, input logic [15:0] tg,
                     input logic [15:0] pn, input logic [3:0] f, input int pend_n, input int gap);
    int cur, acc, ack_c;
    bit tk;
    exp_t e;
    repeat (gap) begin
      req = 1'b0;
      flagsO = 4'($urandom);
      flags_pend = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    cur   = cyc;
    acc   = (cur > free_c) ? cur : free_c;
    ack_c = acc + 2 + pend_n;
    tk    = model_taken(o, s, f);
    e.ack_c = ack_c; e.tk = tk; e.op = o; e.tgt = tg; e.pcn = pn;
    q.push_back(e);
    for (int c = acc + 1; c < ack_c; c++) exp_busy[c] = 1'b1;
    if (tk) for (int c = ack_c; c < ack_c + FC; c++) begin
      exp_busy[c] = 1'b1;
      exp_flush[c] = 1'b1;
    end
    free_c = tk ? ack_c + FC : ack_c + 1;
    req = 1'b1; op = o; sel = s; target = tg; pc_next = pn;
    for (int c = cur; c <= ack_c; c++) begin
      if (c < acc) flags_pend = 1'($urandom_range(0, 1));
      else flags_pend = (c < acc + pend_n);
      flagsO = (c == acc + pend_n) ? f : 4'($urandom);
      if (c != ack_c) @(negedge clk);
    end
  endtask

  // Monitor: per-cycle busy/flush, and ack contents against the scoreboard.
  always @(negedge clk) begin
    if (mon_en && cyc < MAXC) begin
      bit exp_ack;
      chk("busy", 64'(busy), 64'(exp_busy[cyc]));
      chk("flush", 64'(flush), 64'(exp_flush[cyc]));
      while (q.size() > 0 && q[0].ack_c < cyc) void'(q.pop_front());
      exp_ack = (q.size() > 0 && q[0].ack_c == cyc);
      chk("ack", 64'(ack), 64'(exp_ack));
      if (exp_ack) begin
        mon_e = q.pop_front();
        if (mon_e.tk) last_tgt = mon_e.tgt;
        if (mon_e.op == 2'b11) last_link = mon_e.pcn;
        chk("taken", 64'(taken), 64'(mon_e.tk));
        chk("pc_load", 64'(pc_load), 64'(mon_e.tk));
        chk("link_we", 64'(link_we), 64'(mon_e.op == 2'b11));
        chk("pc_target", 64'(pc_target), 64'(last_tgt));
        chk("link_data", 64'(link_data), 64'(last_link));
      end else begin
        chk("pc_load_idle", 64'(pc_load), 64'd0);
        chk("link_we_idle", 64'(link_we), 64'd0);
      end
    end
  end

  initial begin
    r = 1'b1; req = 1'b0; op = '0; sel = '0; target = '0; pc_next = '0;
    flagsO = '0; flags_pend = 1'b0;
    #12;
    chk("reset_outputs", {26'd0, ack, taken, pc_load, link_we, flush, busy, pc_target, link_data}, 64'd0);
    #11 r = 1'b0;
    @(negedge clk);
    free_c = cyc;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);

    txn(2'b11, 3'b110, 16'h0040, 16'h0011, 4'h0, 0, 0);
    txn(2'b01, 3'b010, 16'h0100, 16'h0101, 4'b0000, 0, 0);
    txn(2'b01, 3'b010, 16'h0200, 16'h0201, 4'b0000, 0, 0);
    txn(2'b10, 3'b100, 16'h0300, 16'h0301, 4'b0100, 0, 1);
    txn(2'b10, 3'b100, 16'h0400, 16'h0401, 4'b0000, 0, 0);
    txn(2'b01, 3'b010, 16'h0500, 16'h0501, 4'b0001, 3, 1);

    // Reset in the first flush cycle of a taken branch.
    txn(2'b00, 3'b000, 16'h1234, 16'h5678, 4'h0, 0, 0);
    #2 r = 1'b1;
    #1;
    chk("reset_in_flush", {26'd0, ack, taken, pc_load, link_we, flush, busy, pc_target, link_data}, 64'd0);
    for (int c = cyc; c < cyc + FC + 4; c++) begin
      exp_busy[c] = 1'b0;
      exp_flush[c] = 1'b0;
    end
    last_tgt = '0; last_link = '0; req = 1'b0;
    #1 r = 1'b0;
    free_c = cyc + 1;
    @(negedge clk);
    txn(2'b11, 3'b000, 16'h0abc, 16'h0def, 4'h0, 0, 0);

    for (int i = 0; i < 250; i++) begin
      int pn;
      pn = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      txn(2'($urandom), 3'($urandom), 16'($urandom), 16'($urandom), 4'($urandom),
          pn, int'($urandom_range(0, 2)));
    end

    @(negedge clk);
    req = 1'b0;
    repeat (10) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
